mem_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency data/instruction SRAM between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Serialises accesses and sequences the SRAM wait states.
- Generates the freeze signals that stall the 5-stage pipeline while an access is outstanding.
- Sits between the IF_Stage/MEM_Stage and the memory model, next to the top-level pipeline.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM SRAM arbiter: FSM state, grant owner, counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one fixed-latency SRAM and
// produces the pipeline freeze signals while an access is outstanding.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_e        state_q;
  grant_e            grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              drop_q;
  logic              sram_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic              mem_req;

  assign mem_req = mem_rd | mem_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_q     <= GRANT_IF;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      drop_q      <= 1'b0;
      sram_en_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          // MEM holds the older instruction, so it always wins a tie.
          if (mem_req) begin
            grant_q   <= GRANT_MEM;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            we_q      <= mem_wr;
            cnt_q     <= CNT_LOAD;
            sram_en_q <= 1'b1;
            state_q   <= ARB_ACCESS;
          end else if (if_req) begin
            grant_q   <= GRANT_IF;
            addr_q    <= if_addr;
            we_q      <= 1'b0;
            drop_q    <= if_flush;
            cnt_q     <= CNT_LOAD;
            sram_en_q <= 1'b1;
            state_q   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (grant_q == GRANT_IF && if_flush) drop_q <= 1'b1;
          if (cnt_q == '0) begin
            sram_en_q <= 1'b0;
            state_q   <= ARB_DONE;
            if (grant_q == GRANT_MEM) begin
              mem_ready_q <= 1'b1;
              if (!we_q) mem_rdata_q <= sram_rdata;
            end else if (!(drop_q || if_flush)) begin
              // A flush in the final access cycle must still cancel the fetch.
              if_ready_q <= 1'b1;
              if_rdata_q <= sram_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ARB_DONE: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign sram_en     = sram_en_q;
  assign sram_we     = sram_en_q & we_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_ready    = if_ready_q;
  assign mem_ready   = mem_ready_q;

  assign freeze_pipe = mem_req & ~mem_ready_q;
  assign freeze_if   = freeze_pipe | (if_req & ~if_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random requester traffic,
// all checked cycle by cycle against a transaction-level timing model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned WC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_rd, mem_wr, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          freeze_if, freeze_pipe;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .freeze_pipe(freeze_pipe),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: a grant at cycle g occupies cycles g+1..g+WC on
  // the SRAM, completes at g+WC+1 and frees the arbiter from g+WC+2.
  int          cyc;
  bit          m_busy, m_mem, m_we, m_drop;
  int          m_g;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
  logic [31:0] rd_hist [0:8191];
  bit          e_if_ready, e_mem_ready;

  task automatic model_reset();
    m_busy = 0; m_mem = 0; m_we = 0; m_drop = 0; m_g = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
  endtask

  task automatic idle_inputs();
    rst = 0; if_req = 0; if_flush = 0; if_addr = '0;
    mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_wdata = '0;
  endtask

  // Called #1 after a rising edge with this cycle's inputs already driven.
  task automatic step();
    bit in_acc, at_done, was_busy, e_fp, e_fi;
    #1;
    was_busy = m_busy;
    in_acc   = m_busy && cyc > m_g && cyc <= m_g + int'(WC);
    at_done  = m_busy && cyc == m_g + int'(WC) + 1;
    e_mem_ready = at_done && m_mem;
    e_if_ready  = at_done && !m_mem && !m_drop;
    if (at_done && !m_we) begin
      if (m_mem) m_mem_rdata = rd_hist[m_g + int'(WC)];
      else if (!m_drop) m_if_rdata = rd_hist[m_g + int'(WC)];
    end
    rd_hist[cyc] = sram_rdata;
    e_fp = (mem_rd | mem_wr) && !e_mem_ready;
    e_fi = e_fp || (if_req && !e_if_ready);

    check("sram_en",     sram_en,     in_acc);
    check("sram_we",     sram_we,     in_acc && m_we);
    check("sram_addr",   sram_addr,   m_addr);
    check("sram_wdata",  sram_wdata,  m_wdata);
    check("mem_ready",   mem_ready,   e_mem_ready);
    check("if_ready",    if_ready,    e_if_ready);
    check("mem_rdata",   mem_rdata,   m_mem_rdata);
    check("if_rdata",    if_rdata,    m_if_rdata);
    check("freeze_pipe", freeze_pipe, e_fp);
    check("freeze_if",   freeze_if,   e_fi);

    if (rst) begin
      model_reset();
    end else begin
      if (in_acc && !m_mem && if_flush) m_drop = 1;
      if (at_done) m_busy = 0;
      if (!was_busy) begin
        if (mem_rd | mem_wr) begin
          m_mem = 1; m_we = mem_wr; m_addr = mem_addr; m_wdata = mem_wdata;
          m_g = cyc; m_busy = 1;
        end else if (if_req) begin
          m_mem = 0; m_we = 0; m_addr = if_addr; m_drop = if_flush;
          m_g = cyc; m_busy = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  bit          if_pend, mem_pend;

  initial begin
    idle_inputs();
    rst = 1;
    sram_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    cyc = 0;

    // Reset state, with a load request visible on freeze during reset.
    mem_rd = 1; mem_addr = 32'h100;
    step();
    idle_inputs();
    step();

    // IF fetch.
    sram_rdata = 32'hE3A01005;
    for (int i = 0; i < 6; i++) begin
      if_req = (i <= 4); if_addr = 32'h10;
      step();
    end
    check("t1_if_rdata", if_rdata, 32'hE3A01005);

    // Simultaneous IF and MEM; MEM wins.
    for (int i = 0; i < 11; i++) begin
      sram_rdata = $urandom;
      mem_rd = (i <= 4); mem_addr = 32'h400;
      if_req = (i <= 9); if_addr = 32'h20;
      step();
    end
    idle_inputs();

    // Store; mem_rdata must keep the previous load value.
    for (int i = 0; i < 6; i++) begin
      sram_rdata = $urandom;
      mem_wr = (i <= 4); mem_addr = 32'h404; mem_wdata = 32'hDEADBEEF;
      step();
    end
    idle_inputs();

    // Flush in the 2nd access cycle, then a refetch to 0x80.
    for (int i = 0; i < 11; i++) begin
      sram_rdata = $urandom;
      if_req = (i <= 9); if_addr = (i <= 4) ? 32'h40 : 32'h80;
      if_flush = (i == 2);
      step();
    end
    idle_inputs();

    // Reset in the 2nd access cycle with the load held through reset.
    for (int i = 0; i < 9; i++) begin
      sram_rdata = $urandom;
      mem_rd = (i <= 7); mem_addr = 32'h408;
      rst = (i == 2);
      step();
    end
    idle_inputs();

    // Back-to-back loads with mem_rd held.
    for (int i = 0; i < 11; i++) begin
      sram_rdata = $urandom;
      mem_rd = (i <= 9); mem_addr = (i <= 4) ? 32'h400 : 32'h408;
      step();
    end
    idle_inputs();
    step();

    // Random requester traffic.
    if_pend = 0; mem_pend = 0;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      sram_rdata = $urandom;
      if (mem_pend && e_mem_ready) mem_pend = 0;
      if (if_pend && e_if_ready) if_pend = 0;
      if (!mem_pend && $urandom_range(0, 3) == 0) begin
        mem_pend  = 1;
        mem_addr  = {$urandom_range(0, 4095), 2'b00};
        mem_wdata = $urandom;
        case ($urandom_range(0, 6))
          0, 1, 2: begin mem_rd = 1; mem_wr = 0; end
          3, 4, 5: begin mem_rd = 0; mem_wr = 1; end
          default: begin mem_rd = 1; mem_wr = 1; end
        endcase
      end else if (!mem_pend) begin
        mem_rd = 0; mem_wr = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        mem_addr  = {$urandom_range(0, 4095), 2'b00};
        mem_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 9) == 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        if_addr = {$urandom_range(0, 4095), 2'b00};
      end else if (if_pend && if_flush) begin
        if_addr = {$urandom_range(0, 4095), 2'b00};
      end
      if_req = if_pend;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
